// File: rtl/red_pitaya_asg_pkg.sv
// Shared sweep-generator types: controller states, sweep mode codes and mode normalisation.
package red_pitaya_asg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_HOLD  = 2'd2
  } sweep_state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  // Code 3 is unused and behaves as a single sweep.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_SINGLE : mode;
  endfunction

endpackage

// File: rtl/red_pitaya_asg_sweep_dwell.sv
// Dwell counter: loaded on sweep start, counts down while running, reloads at zero.
module red_pitaya_asg_sweep_dwell (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        run,
  input  logic [31:0] reload_val,
  output logic        expire
);

  logic [31:0] cnt;

  assign expire = (cnt == 32'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 32'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run) begin
      cnt <= expire ? reload_val : cnt - 32'd1;
    end
  end

endmodule

// File: rtl/red_pitaya_asg_sweep.sv
// Frequency sweep controller for an ASG channel phase step.
// Build option: define ASG_SWEEP_RETRIG_EN to let trig_i restart a running sweep.
module red_pitaya_asg_sweep
  import red_pitaya_asg_pkg::*;
#(
  parameter int RSZ = 14
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  input  logic              trig_i,
  input  logic              set_rst_i,
  input  logic [1:0]        set_mode_i,
  input  logic [RSZ+15:0]   set_start_i,
  input  logic [RSZ+15:0]   set_stop_i,
  input  logic [RSZ+15:0]   set_inc_i,
  input  logic [31:0]       set_dwell_i,
  output logic [RSZ+15:0]   step_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int SW = RSZ + 16;

  sweep_state_e  state;
  logic [SW-1:0] start_sh, stop_sh, inc_sh;
  logic [31:0]   dwell_sh;
  logic [1:0]    mode_sh;
  logic          dir_up;     // start <= stop
  logic          leg_out;    // heading toward stop (vs. back toward start)
  logic          wrap_pend;  // sawtooth: jump to start at next dwell expiry
  logic          accept, dwell_expire;

`ifdef ASG_SWEEP_RETRIG_EN
  assign accept = trig_i && !set_rst_i;
`else
  assign accept = trig_i && !set_rst_i && (state != ST_SWEEP);
`endif

  red_pitaya_asg_sweep_dwell u_dwell (
    .clk        (dac_clk_i),
    .rst_n      (dac_rstn_i),
    .load       (accept),
    .load_val   (set_dwell_i),
    .run        (state == ST_SWEEP),
    .reload_val (dwell_sh),
    .expire     (dwell_expire)
  );

  logic [SW-1:0] target, next_step;
  logic [SW:0]   sum_up, diff_dn;
  logic          leg_end;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    target    = leg_out ? stop_sh : start_sh;
    sum_up    = {1'b0, step_o} + {1'b0, inc_sh};
    diff_dn   = {1'b0, step_o} - {1'b0, inc_sh};
    next_step = sum_up[SW-1:0];
    leg_end   = 1'b0;
    if (leg_out ? dir_up : !dir_up) begin
      leg_end = (sum_up >= {1'b0, target});
    end else begin
      next_step = diff_dn[SW-1:0];
      // A borrow means the step went below zero, which is past any target.
      leg_end   = diff_dn[SW] || (diff_dn[SW-1:0] <= target);
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state     <= ST_IDLE;
      step_o    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      start_sh  <= '0;
      stop_sh   <= '0;
      inc_sh    <= '0;
      dwell_sh  <= '0;
      mode_sh   <= MODE_SINGLE;
      dir_up    <= 1'b0;
      leg_out   <= 1'b0;
      wrap_pend <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (set_rst_i) begin
        state     <= ST_IDLE;
        busy_o    <= 1'b0;
        step_o    <= set_start_i;
        wrap_pend <= 1'b0;
      end else if (accept) begin
        start_sh  <= set_start_i;
        stop_sh   <= set_stop_i;
        inc_sh    <= set_inc_i;
        dwell_sh  <= set_dwell_i;
        mode_sh   <= norm_mode(set_mode_i);
        dir_up    <= (set_start_i <= set_stop_i);
        leg_out   <= 1'b1;
        wrap_pend <= 1'b0;
        step_o    <= set_start_i;
        busy_o    <= 1'b1;
        state     <= ST_SWEEP;
      end else begin
        case (state)
          ST_IDLE: begin
            step_o <= set_start_i;
            busy_o <= 1'b0;
          end
          ST_SWEEP: begin
            if (dwell_expire) begin
              if (wrap_pend) begin
                step_o    <= start_sh;
                wrap_pend <= 1'b0;
              end else if (inc_sh != '0) begin
                if (leg_end) begin
                  step_o <= target;
                  case (mode_sh)
                    MODE_SAW: begin
                      done_o    <= 1'b1;
                      wrap_pend <= 1'b1;
                    end
                    MODE_TRI: begin
                      leg_out <= !leg_out;
                      done_o  <= !leg_out;
                    end
                    default: begin
                      done_o <= 1'b1;
                      busy_o <= 1'b0;
                      state  <= ST_HOLD;
                    end
                  endcase
                end else begin
                  step_o <= next_step;
                end
              end
            end
          end
          ST_HOLD: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Directed self-checking bench for red_pitaya_asg_sweep (honours ASG_SWEEP_RETRIG_EN).
module tb_red_pitaya_asg_sweep;

  localparam int RSZ = 14;
  localparam int SW  = RSZ + 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          trig = 1'b0;
  logic          set_rst = 1'b0;
  logic [1:0]    set_mode = 2'd0;
  logic [SW-1:0] set_start = '0, set_stop = '0, set_inc = '0;
  logic [31:0]   set_dwell = '0;
  logic [SW-1:0] step;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  red_pitaya_asg_sweep #(.RSZ(RSZ)) dut (
    .dac_clk_i   (clk),
    .dac_rstn_i  (rstn),
    .trig_i      (trig),
    .set_rst_i   (set_rst),
    .set_mode_i  (set_mode),
    .set_start_i (set_start),
    .set_stop_i  (set_stop),
    .set_inc_i   (set_inc),
    .set_dwell_i (set_dwell),
    .step_o      (step),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] m, input int s, input int e, input int inc, input int dw);
    set_mode  = m;
    set_start = SW'(s);
    set_stop  = SW'(e);
    set_inc   = SW'(inc);
    set_dwell = 32'(dw);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic clear_sweep();
    set_rst = 1'b1;
    tick();
    set_rst = 1'b0;
  endtask

  task automatic test_reset();
    set_start = SW'(77);
    #3;
    checks++;
    if (step !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state step=%0d busy=%b done=%b want 0/0/0", step, busy, done);
    end
    #9 rstn = 1'b1;
    tick();
    checks++;
    if (step !== SW'(77) || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_idle step=%0d busy=%b want 77/0", step, busy);
    end
  endtask

  task automatic test_single_up();
    int exp_s;
    cfg(2'd0, 100, 130, 10, 2);
    pulse_trig();
    for (int i = 0; i < 12; i++) begin
      exp_s = 100 + 10 * (i / 3);
      checks++;
      if (step !== SW'(exp_s) || done !== (i == 9) || busy !== (i < 9)) begin
        errors++;
        $display("FAIL single_up[%0d] step=%0d done=%b busy=%b want %0d/%b/%b",
                 i, step, done, busy, exp_s, (i == 9), (i < 9));
      end
      tick();
    end
  endtask

  task automatic test_clamp();
    int exp_s[5] = '{100, 110, 120, 125, 125};
    cfg(2'd0, 100, 125, 10, 0);
    pulse_trig();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (step !== SW'(exp_s[i]) || done !== (i == 3)) begin
        errors++;
        $display("FAIL clamp[%0d] step=%0d done=%b want %0d/%b", i, step, done, exp_s[i], (i == 3));
      end
      tick();
    end
  endtask

  task automatic test_triangle();
    int exp_s[9] = '{0, 10, 20, 10, 0, 10, 20, 10, 0};
    cfg(2'd2, 0, 20, 10, 0);
    pulse_trig();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (step !== SW'(exp_s[i]) || done !== (i == 4 || i == 8) || busy !== 1'b1) begin
        errors++;
        $display("FAIL triangle[%0d] step=%0d done=%b busy=%b want %0d/%b/1",
                 i, step, done, busy, exp_s[i], (i == 4 || i == 8));
      end
      tick();
    end
    clear_sweep();
  endtask

  task automatic test_saw_rst_priority();
    int exp_s[11] = '{0, 0, 10, 10, 20, 20, 30, 30, 0, 0, 10};
    cfg(2'd1, 0, 30, 10, 1);
    pulse_trig();
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (step !== SW'(exp_s[i]) || done !== (i == 6)) begin
        errors++;
        $display("FAIL saw[%0d] step=%0d done=%b want %0d/%b", i, step, done, exp_s[i], (i == 6));
      end
      tick();
    end
    set_start = SW'(55);
    set_rst = 1'b1;
    trig = 1'b1;
    tick();
    set_rst = 1'b0;
    trig = 1'b0;
    checks++;
    if (step !== SW'(55) || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_over_trig step=%0d busy=%b done=%b want 55/0/0", step, busy, done);
    end
    set_start = SW'(66);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (step !== SW'(66) || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_follow[%0d] step=%0d busy=%b done=%b want 66/0/0", i, step, busy, done);
      end
    end
  endtask

  task automatic test_descend();
    int exp_s[5] = '{500, 400, 300, 200, 200};
    cfg(2'd0, 500, 200, 100, 0);
    pulse_trig();
    set_stop  = SW'(450);
    set_start = SW'(0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (step !== SW'(exp_s[i]) || done !== (i == 3) || busy !== (i < 3)) begin
        errors++;
        $display("FAIL descend[%0d] step=%0d done=%b busy=%b want %0d/%b/%b",
                 i, step, done, busy, exp_s[i], (i == 3), (i < 3));
      end
      tick();
    end
  endtask

  task automatic test_equal_and_zero_inc();
    cfg(2'd3, 50, 50, 5, 3);
    pulse_trig();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (step !== SW'(50) || done !== (i == 4) || busy !== (i < 4)) begin
        errors++;
        $display("FAIL equal[%0d] step=%0d done=%b busy=%b want 50/%b/%b",
                 i, step, done, busy, (i == 4), (i < 4));
      end
      tick();
    end
    cfg(2'd0, 40, 80, 0, 0);
    pulse_trig();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (step !== SW'(40) || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL zero_inc[%0d] step=%0d done=%b busy=%b want 40/0/1", i, step, done, busy);
      end
      tick();
    end
    clear_sweep();
  endtask

  task automatic test_async_reset_retrig();
    cfg(2'd0, 0, 1000, 1, 0);
    pulse_trig();
    tick();
    tick();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (step !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset step=%0d busy=%b done=%b want 0/0/0", step, busy, done);
    end
    set_start = SW'(321);
    #1 rstn = 1'b1;
    tick();
    checks++;
    if (step !== SW'(321) || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle step=%0d busy=%b want 321/0", step, busy);
    end
    cfg(2'd0, 0, 1000, 1, 0);
    pulse_trig();
    tick();
    tick();
    checks++;
    if (step !== SW'(2) || busy !== 1'b1) begin
      errors++;
      $display("FAIL retrig_pre step=%0d busy=%b want 2/1", step, busy);
    end
    cfg(2'd0, 5000, 6000, 1, 0);
    pulse_trig();
    checks++;
`ifdef ASG_SWEEP_RETRIG_EN
    if (step !== SW'(5000) || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL retrig step=%0d busy=%b done=%b want 5000/1/0", step, busy, done);
    end
`else
    if (step !== SW'(3) || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL retrig_ignored step=%0d busy=%b done=%b want 3/1/0", step, busy, done);
    end
`endif
    clear_sweep();
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_clamp();
    test_triangle();
    test_saw_rst_priority();
    test_descend();
    test_equal_and_zero_inc();
    test_async_reset_retrig();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
